// File: rtl/alu_arbiter_if.sv
// Bundle of request, operand, grant and result signals shared by the two
// ALU requesters and alu_arbiter.
interface alu_arbiter_if;
  logic [1:0] Req;
  logic [3:0] Data0;
  logic [3:0] Data1;
  logic [1:0] Func0;
  logic [1:0] Func1;
  logic [1:0] Gnt;
  logic       Busy;
  logic       Done;
  logic [7:0] ALUout;

  modport master (
    output Req, Data0, Data1, Func0, Func1,
    input  Gnt, Busy, Done, ALUout
  );

  modport slave (
    input  Req, Data0, Data1, Func0, Func1,
    output Gnt, Busy, Done, ALUout
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU with an 8-bit accumulator.
// Defining ALU_ARB_FIXED_PRIORITY_EN gives requester 0 fixed priority instead of round-robin.
module alu_arbiter (
  input  logic         Clock,
  input  logic         Reset_b,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] EXEC   = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;
  localparam logic [1:0] F_ADD  = 2'b00;
  localparam logic [1:0] F_MUL  = 2'b01;
  localparam logic [1:0] F_SHL  = 2'b10;
  localparam logic [1:0] F_HOLD = 2'b11;

  logic [1:0] state_r;
  logic [1:0] gnt_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] alu_r;
  logic [3:0] data_r;
  logic [1:0] func_r;
  logic [3:0] a_r;
  logic [7:0] acc_r;
  logic [1:0] cnt_r;
  logic       win_s;
  logic [7:0] pp_s;
  logic [7:0] next_acc_s;

  // Result of the operations that finish in a single EXEC cycle.
  function automatic logic [7:0] single_cycle_result(
    input logic [1:0] func,
    input logic [3:0] data,
    input logic [3:0] a,
    input logic [7:0] cur
  );
    logic [7:0] res;
    case (func)
      F_ADD:   res = {4'b0000, data} + {4'b0000, a};
      F_SHL:   res = {4'b0000, a} << data;
      F_HOLD:  res = cur;
      default: res = cur;
    endcase
    return res;
  endfunction

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  // Winner selection: requester 0 beats requester 1 whenever it asks.
  always_comb begin
    win_s = 1'b0;
    if (bus.Req[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`else
  logic last_r;

  // Round-robin pointer: remembers who was served, advanced only when an operation retires.
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      last_r <= 1'b1;
    end else if (state_r == DONE) begin
      last_r <= gnt_r[1];
    end else begin
      last_r <= last_r;
    end
  end

  // Winner selection: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    win_s = 1'b0;
    if (bus.Req == 2'b11) begin
      win_s = ~last_r;
    end else if (bus.Req[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end
`endif

  // Shift-add multiply step: add A shifted by the current operand bit position.
  always_comb begin
    pp_s       = 8'h00;
    next_acc_s = acc_r;
    if (data_r[cnt_r]) begin
      pp_s = {4'b0000, a_r} << cnt_r;
    end else begin
      pp_s = 8'h00;
    end
    next_acc_s = acc_r + pp_s;
  end

  // Control FSM, operand capture and accumulator update.
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      state_r <= IDLE;
      gnt_r   <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      alu_r   <= 8'h00;
      data_r  <= 4'h0;
      func_r  <= 2'b00;
      a_r     <= 4'h0;
      acc_r   <= 8'h00;
      cnt_r   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.Req) begin
            state_r <= EXEC;
            gnt_r   <= win_s ? 2'b10 : 2'b01;
            busy_r  <= 1'b1;
            data_r  <= win_s ? bus.Data1 : bus.Data0;
            func_r  <= win_s ? bus.Func1 : bus.Func0;
            a_r     <= alu_r[3:0];
            acc_r   <= 8'h00;
            cnt_r   <= 2'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (func_r == F_MUL) begin
            if (cnt_r == 2'd3) begin
              alu_r   <= next_acc_s;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              acc_r <= next_acc_s;
              cnt_r <= cnt_r + 2'd1;
            end
          end else begin
            alu_r   <= single_cycle_result(func_r, data_r, a_r, alu_r);
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Gnt    = gnt_r;
  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.ALUout = alu_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized operations
// compared against an arithmetic reference model (honours ALU_ARB_FIXED_PRIORITY_EN).
module tb_alu_arbiter;

  logic Clock;
  logic Reset_b;
  int   checks;
  int   errors;
  logic [7:0] acc_m;
  int   last_m;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One complete operation; the model predicts winner, result and latency.
  task automatic do_op(input logic [1:0] req, input logic [3:0] d0, input logic [1:0] f0,
                       input logic [3:0] d1, input logic [1:0] f1,
                       input bit drop, input bit keep);
    int w, d, f, a, r, lat;
    logic [7:0] old_acc;
    logic [1:0] gnt_exp;
    if (req == 2'b01) w = 0;
    else if (req == 2'b10) w = 1;
    else begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      w = 0;
`else
      w = (last_m == 1) ? 0 : 1;
`endif
    end
    d = (w == 1) ? int'(d1) : int'(d0);
    f = (w == 1) ? int'(f1) : int'(f0);
    a = int'(acc_m) % 16;
    case (f)
      0:       r = d + a;
      1:       r = d * a;
      2:       r = (d >= 8) ? 0 : ((a << d) % 256);
      default: r = int'(acc_m);
    endcase
    lat     = (f == 1) ? 4 : 1;
    old_acc = acc_m;
    gnt_exp = (w == 1) ? 2'b10 : 2'b01;

    bus.Req = req; bus.Data0 = d0; bus.Func0 = f0; bus.Data1 = d1; bus.Func1 = f1;
    @(posedge Clock); #1;
    chk("grant", {6'b0, bus.Gnt}, {6'b0, gnt_exp});
    chk("busy_exec", {7'b0, bus.Busy}, 8'h01);
    chk("done_low_at_grant", {7'b0, bus.Done}, 8'h00);
    chk("alu_at_grant", bus.ALUout, old_acc);
    // operands are latched at grant, so later changes must be ignored
    bus.Data0 = 4'($urandom); bus.Data1 = 4'($urandom);
    bus.Func0 = 2'($urandom); bus.Func1 = 2'($urandom);
    if (drop) bus.Req = 2'b00;
    for (int c = 1; c < lat; c++) begin
      @(posedge Clock); #1;
      chk("done_low_exec", {7'b0, bus.Done}, 8'h00);
      chk("alu_stable_exec", bus.ALUout, old_acc);
      chk("grant_held", {6'b0, bus.Gnt}, {6'b0, gnt_exp});
    end
    @(posedge Clock); #1;
    chk("done_pulse", {7'b0, bus.Done}, 8'h01);
    chk("result", bus.ALUout, 8'(r));
    chk("grant_on_done", {6'b0, bus.Gnt}, {6'b0, gnt_exp});
    acc_m  = 8'(r);
    last_m = w;
    if (!keep) bus.Req = 2'b00;
    @(posedge Clock); #1;
    chk("done_cleared", {7'b0, bus.Done}, 8'h00);
    chk("grant_cleared", {6'b0, bus.Gnt}, 8'h00);
    chk("busy_cleared", {7'b0, bus.Busy}, 8'h00);
    chk("result_kept", bus.ALUout, acc_m);
  endtask

  initial begin
    logic [1:0] rq;
    checks = 0; errors = 0;
    acc_m = 8'h00; last_m = 1;
    Reset_b = 1'b1;
    bus.Req = 2'b00; bus.Data0 = 4'h0; bus.Data1 = 4'h0;
    bus.Func0 = 2'b00; bus.Func1 = 2'b00;
    #2;
    chk("reset_alu", bus.ALUout, 8'h00);
    chk("reset_gnt", {6'b0, bus.Gnt}, 8'h00);
    chk("reset_busy", {7'b0, bus.Busy}, 8'h00);
    chk("reset_done", {7'b0, bus.Done}, 8'h00);
    @(posedge Clock); @(posedge Clock); #1;
    Reset_b = 1'b0;

    // add 5 from zero, then build 0x0D and multiply by 7 on requester 1
    do_op(2'b01, 4'd5, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0);
    do_op(2'b01, 4'd8, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0);
    chk("alu_0d", bus.ALUout, 8'h0D);
    do_op(2'b10, 4'd0, 2'b00, 4'd7, 2'b01, 1'b0, 1'b0);
    chk("mul_91", bus.ALUout, 8'h5B);

    // shift boundaries: amount 9 clears, amount 6 of 3 gives 0xC0
    do_op(2'b01, 4'd8, 2'b10, 4'd0, 2'b00, 1'b0, 1'b0);
    do_op(2'b01, 4'd3, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0);
    do_op(2'b01, 4'd9, 2'b10, 4'd0, 2'b00, 1'b0, 1'b0);
    chk("shl_9", bus.ALUout, 8'h00);
    do_op(2'b01, 4'd3, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0);
    do_op(2'b01, 4'd6, 2'b10, 4'd0, 2'b00, 1'b0, 1'b0);
    chk("shl_6", bus.ALUout, 8'hC0);

    // requester drops Req right after grant; operation still completes
    do_op(2'b01, 4'd4, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0);
    do_op(2'b01, 4'd2, 2'b00, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("drop_result", bus.ALUout, 8'h06);

    // serve requester 1 once, then hold both requests over four operations
    do_op(2'b10, 4'd0, 2'b00, 4'd1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_op(2'b11, 4'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 1'b0, 1'b1);
    end
    bus.Req = 2'b00;
    @(posedge Clock); #1;

    for (int i = 0; i < 24; i++) begin
      rq = 2'($urandom_range(1, 3));
      do_op(rq, 4'($urandom), 2'($urandom), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0), 1'b0);
    end

    // reset pulsed between edges while a multiply is in EXEC
    do_op(2'b01, 4'd7, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0);
    bus.Req = 2'b10; bus.Data1 = 4'd15; bus.Func1 = 2'b01;
    @(posedge Clock); #1;
    bus.Req = 2'b00;
    @(posedge Clock); @(posedge Clock); #2;
    Reset_b = 1'b1;
    #1;
    chk("rst_mid_alu", bus.ALUout, 8'h00);
    chk("rst_mid_gnt", {6'b0, bus.Gnt}, 8'h00);
    chk("rst_mid_busy", {7'b0, bus.Busy}, 8'h00);
    chk("rst_mid_done", {7'b0, bus.Done}, 8'h00);
    #1;
    Reset_b = 1'b0;
    acc_m = 8'h00; last_m = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      chk("post_rst_no_done", {7'b0, bus.Done}, 8'h00);
      chk("post_rst_alu", bus.ALUout, 8'h00);
    end
    // first tie after reset goes to requester 0
    do_op(2'b11, 4'd9, 2'b00, 4'd3, 2'b00, 1'b0, 1'b0);
    chk("post_rst_tie", bus.ALUout, 8'h09);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide port Clock, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL provide port Reset_b, input, 1: asynchronous, active-high reset (1 = reset asserted).
REQ-003 SHALL provide port Req, input, 2: Req[i] = requester i wants one ALU operation; held until Done seen with Gnt[i].
REQ-004 SHALL provide ports Data0 / Data1, input, 4 each: operand of requester 0 / 1.
REQ-005 SHALL provide ports Func0 / Func1, input, 2 each: opcode of requester 0 / 1 (00 add, 01 multiply, 10 shift-left, 11 hold).
REQ-006 SHALL provide port Gnt, output, 2: one-hot-or-zero grant; high for whole operation including Done cycle.
REQ-007 SHALL provide port Busy, output, 1: high in any state other than IDLE.
REQ-008 SHALL provide port Done, output, 1: single-cycle pulse marking result valid.
REQ-009 SHALL provide port ALUout, output, 8: shared accumulator.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, DONE; IDLE->EXEC on any Req bit; EXEC->DONE when operation completes; DONE->IDLE unconditionally.
REQ-011 SHALL, on the IDLE->EXEC edge, latch winner's Data/Func and assert Gnt of winner; later Data/Func changes ignored until next grant.
REQ-012 SHALL arbitrate round-robin: single requester wins; both requesting -> requester not granted last wins.
REQ-013 SHALL compute with A = ALUout[3:0] sampled at grant: add = zero-extended Data+A (max 30); multiply = Data*A (max 225); shift = {4'b0,A} << Data truncated to 8 bits (Data>=8 gives 0); hold = ALUout unchanged.
REQ-014 SHALL complete add, shift, hold in 1 EXEC cycle and multiply in exactly 4 EXEC cycles (sequential shift-add, one operand bit per cycle).
REQ-015 SHALL update ALUout and assert Done on the EXEC->DONE edge: grant at edge k -> Done high after edge k+1 (add/shift/hold) or k+4 (multiply); ALUout unchanged during EXEC.
REQ-016 SHALL deassert Gnt, Done, Busy on the DONE->IDLE edge; IDLE lasts at least one cycle between operations.
REQ-017 SHALL NOT abort when granted requester drops Req mid-operation; operation completes and result is written.
REQ-018 SHALL update the round-robin pointer on the DONE->IDLE edge only.
REQ-019 SHALL keep Gnt at most one bit high at all times.

Reset
REQ-020 SHALL, while Reset_b=1, immediately (no clock) force ALUout=8'h00, Gnt=2'b00, Done=0, Busy=0, state IDLE, pointer = "last granted 1" (requester 0 wins first tie).
REQ-021 SHALL discard any in-flight operation on reset, including a multiply in EXEC, without writing ALUout.
REQ-022 SHALL begin arbitration on the first rising edge after Reset_b deasserts.

Configuration
REQ-023 SHALL, with macro ALU_ARB_FIXED_PRIORITY_EN defined, replace round-robin by fixed priority (requester 0 always wins ties; pointer logic absent).
REQ-024 SHALL, without ALU_ARB_FIXED_PRIORITY_EN, use round-robin per REQ-012/REQ-018.

Verification
REQ-025 SHALL cover: reset, Req=01, Data0=5, Func0=00 -> Gnt=01 one edge later, Done and ALUout=8'h05 one edge after that.
REQ-026 SHALL cover: ALUout=8'h0D, Req=10, Data1=7, Func1=01 -> Done 4 edges after grant, ALUout=8'h5B (91), ALUout stable during EXEC.
REQ-027 SHALL cover: ALUout=8'h03, Func0=10, Data0=9 -> ALUout=8'h00; Data0=6 -> ALUout=8'hC0.
REQ-028 SHALL cover: Req=11 held for 4 operations -> grants 01,10,01,10 (round-robin); with ALU_ARB_FIXED_PRIORITY_EN -> 01,01,01,01.
REQ-029 SHALL cover: Reset_b pulsed between clock edges during multiply EXEC -> outputs zero immediately, no Done, ALUout=8'h00.
REQ-030 SHALL cover: granted requester drops Req after grant, Func=00, Data=2, ALUout=8'h04 -> Done still pulses, ALUout=8'h06.
